// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - Register offsets relative to the peripheral base address.
//   - CON register bit positions.
//   - Transmit FSM state encoding.
//   - Baud counter width helper.
package uart_pkg;

    localparam logic [31:0] TXD_OFFSET = 32'd0;
    localparam logic [31:0] CON_OFFSET = 32'd4;

    localparam int CON_IE    = 0;
    localparam int CON_DONE  = 1;
    localparam int CON_BUSY  = 2;
    localparam int CON_FULL  = 3;
    localparam int CON_EMPTY = 4;
    localparam int CON_OVF   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Width of a counter that must reach divisor-1; never narrower than one bit.
    function automatic int baud_cnt_width(input int divisor);
        if (divisor > 1) begin
            return $clog2(divisor);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide synchronous FIFO for queued transmit data.
//   clk, reset : clock and synchronous active-high reset (pointers cleared)
//   push, din  : write request and byte; ignored when full
//   pop        : read request; ignored when empty
//   dout       : byte at the head of the queue (valid while !empty)
//   full,empty : occupancy flags derived from the pointer wrap bits
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [7:0]  mem_r [DEPTH];
    logic        push_ok_s;
    logic        pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flags are evaluated before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter on the MEM-stage bus.
//   clk, reset : clock and synchronous active-high reset
//   MemRead    : read strobe (ReadData is combinational)
//   MemWrite   : write strobe, sampled on the rising edge
//   Addr       : byte address; TXD at BASE_ADDR, CON at BASE_ADDR+4
//   WriteData  : write data
//   ReadData   : read data, 0 when unselected or MemRead low
//   IRQ        : registered CON.ie & CON.done
//   UART_TX    : registered serial line, idle high
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ   = 50_000_000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ,
    output logic        UART_TX
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int CW      = baud_cnt_width(DIVISOR);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

    // Bus decode
    logic        sel_txd_s;
    logic        sel_con_s;
    logic        txd_wr_s;
    logic        con_wr_s;
    logic        push_s;
    logic        ovf_set_s;
    logic [31:0] con_word_s;
    logic        unused_s;

    // FIFO interface
    logic        pop_s;
    logic [7:0]  fifo_dout_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;

    // Registers
    logic        ie_r;
    logic        done_r;
    logic        ovf_r;
    logic        irq_r;
    logic [7:0]  last_r;

    // FSM
    tx_state_e   state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [2:0]  idx_r, idx_n;
    logic [7:0]  shift_r, shift_n;
    logic        tx_r, tx_n;
    logic        done_set_s;

    assign sel_txd_s = (Addr == (BASE_ADDR + TXD_OFFSET));
    assign sel_con_s = (Addr == (BASE_ADDR + CON_OFFSET));
    assign txd_wr_s  = MemWrite & sel_txd_s;
    assign con_wr_s  = MemWrite & sel_con_s;
    // Full is judged before the edge, so a same-edge pop does not rescue the write.
    assign push_s    = txd_wr_s & ~fifo_full_s;
    assign ovf_set_s = txd_wr_s & fifo_full_s;
    assign unused_s  = ^{WriteData[31:8]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Assemble the CON read view from pre-edge state.
    always_comb begin
        con_word_s            = 32'd0;
        con_word_s[CON_IE]    = ie_r;
        con_word_s[CON_DONE]  = done_r;
        con_word_s[CON_BUSY]  = (state_r != IDLE);
        con_word_s[CON_FULL]  = fifo_full_s;
        con_word_s[CON_EMPTY] = fifo_empty_s;
        con_word_s[CON_OVF]   = ovf_r;
    end

    // Combinational read mux.
    always_comb begin
        ReadData = 32'd0;
        if (MemRead) begin
            if (sel_txd_s) begin
                ReadData = {24'd0, last_r};
            end else if (sel_con_s) begin
                ReadData = con_word_s;
            end else begin
                ReadData = 32'd0;
            end
        end else begin
            ReadData = 32'd0;
        end
    end

    // CON register, last-written byte and registered interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_r   <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            irq_r  <= 1'b0;
            last_r <= 8'd0;
        end else begin
            if (con_wr_s) begin
                ie_r <= WriteData[CON_IE];
            end
            // Set wins over a same-edge write-1-clear.
            done_r <= done_set_s | (done_r & ~(con_wr_s & WriteData[CON_DONE]));
            ovf_r  <= ovf_set_s  | (ovf_r  & ~(con_wr_s & WriteData[CON_OVF]));
            irq_r  <= ie_r & done_r;
            if (txd_wr_s) begin
                last_r <= WriteData[7:0];
            end
        end
    end

    // Transmit FSM next-state logic.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        idx_n      = idx_r;
        shift_n    = shift_r;
        tx_n       = tx_r;
        pop_s      = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_n = fifo_dout_s;
                    tx_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = START;
                end else begin
                    tx_n    = 1'b1;
                end
            end
            START: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    tx_n    = shift_r[0];
                    state_n = DATA;
                end else begin
                    cnt_n   = cnt_r + CW'(1);
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n = '0;
                    if (idx_r == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        // Line currently shows shift_r[0]; next bit is shift_r[1].
                        idx_n   = idx_r + 3'd1;
                        tx_n    = shift_r[1];
                        shift_n = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n = '0;
                    if (!fifo_empty_s) begin
                        // Chain straight into the next start bit.
                        pop_s   = 1'b1;
                        shift_n = fifo_dout_s;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        done_set_s = 1'b1;
                        tx_n       = 1'b1;
                        state_n    = IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                cnt_n   = '0;
            end
        endcase
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
        end
    end

    assign IRQ     = irq_r;
    assign UART_TX = tx_r;

endmodule

// File: tb/tb_uart_tx_periph.sv
module tb_uart_tx_periph;

    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] CON  = BASE + 32'd4;
    localparam logic [31:0] UNM  = BASE + 32'd8;
    localparam int BIT_T   = 10;
    localparam int FRAME_T = 10 * BIT_T;
    localparam int FIFO_N  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        IRQ;
    logic        UART_TX;

    uart_tx_periph #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .IRQ       (IRQ),
        .UART_TX   (UART_TX)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    // Reference model: every accepted byte gets a start edge computed from
    // when the line becomes free; FIFO occupancy is the count of bytes not yet started.
    frame_t exp_q[$];
    int     starts_q[$];
    int     tx_free = 0;
    logic   ovf_m = 1'b0;
    int     epoch = 0;
    bit     mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        int e;
        int occ;
        int st;
        @(negedge clk);
        MemRead = 1'b0;
        MemWrite = 1'b1;
        Addr = a;
        WriteData = d;
        e = cyc + 1;
        if (a == TXD) begin
            occ = 0;
            foreach (starts_q[i]) if (starts_q[i] >= e) occ++;
            if (occ >= FIFO_N) begin
                ovf_m = 1'b1;
            end else begin
                st = (e + 1 > tx_free) ? e + 1 : tx_free;
                tx_free = st + FRAME_T;
                starts_q.push_back(st);
                exp_q.push_back('{data: d[7:0], start: st});
            end
        end else if (a == CON) begin
            if (d[5]) ovf_m = 1'b0;
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead = 1'b0;
        Addr = 32'd0;
        WriteData = 32'd0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        MemRead = 1'b1;
        Addr = a;
        #1;
        d = ReadData;
        MemRead = 1'b0;
        check(name, d, exp);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: decode frames from the line and compare against the scoreboard.
    initial begin
        logic       prev;
        int         s;
        int         ep;
        int         j;
        logic [7:0] d;
        logic       frame_ok;
        frame_t     f;
        prev = 1'b1;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && UART_TX === 1'b0) begin
                s = cyc;
                ep = epoch;
                d = 8'h00;
                frame_ok = 1'b1;
                for (int k = 1; k < FRAME_T; k++) begin
                    @(negedge clk);
                    if (k % BIT_T == BIT_T / 2) begin
                        j = k / BIT_T;
                        if (j == 0) begin
                            if (UART_TX !== 1'b0) frame_ok = 1'b0;
                        end else if (j == 9) begin
                            if (UART_TX !== 1'b1) frame_ok = 1'b0;
                        end else begin
                            d[j-1] = UART_TX;
                        end
                    end
                end
                prev = UART_TX;
                if (ep == epoch) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got byte 0x%0h at cycle %0d expected none", d, s);
                    end else begin
                        f = exp_q.pop_front();
                        check("frame_data", {24'd0, d}, {24'd0, f.data});
                        check("frame_start", 32'(s), 32'(f.start));
                        check("frame_format", {31'd0, frame_ok}, 32'd1);
                    end
                end
            end else begin
                prev = UART_TX;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int gap;
        logic [7:0] b;

        // Reset and idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (50) @(negedge clk);
        check("reset_tx", {31'd0, UART_TX}, 32'd1);
        check("reset_irq", {31'd0, IRQ}, 32'd0);
        read_check("reset_con", CON, 32'h10);
        read_check("reset_txd", TXD, 32'h0);

        // Single frame with interrupt
        bus_write(CON, 32'h1);
        bus_write(TXD, 32'hA5);
        bus_idle();
        read_check("txd_readback", TXD, 32'hA5);
        wait_until(tx_free - 1);
        read_check("con_busy_before_done", CON, 32'h15);
        wait_until(tx_free);
        read_check("con_done", CON, 32'h13);
        check("irq_lag", {31'd0, IRQ}, 32'd0);
        wait_until(tx_free + 1);
        check("irq_set", {31'd0, IRQ}, 32'd1);
        bus_write(CON, 32'h3);
        bus_idle();
        @(negedge clk);
        check("irq_cleared", {31'd0, IRQ}, 32'd0);
        read_check("con_after_w1c", CON, 32'h11);

        // Three back-to-back bytes
        for (int i = 0; i < 3; i++) bus_write(TXD, $urandom);
        bus_idle();
        wait_until(tx_free - 1);
        read_check("burst_not_done", CON, 32'h15);
        wait_until(tx_free);
        read_check("burst_done", CON, 32'h13);
        bus_write(CON, 32'h2);
        bus_idle();
        read_check("burst_cleared", CON, 32'h10);

        // Overflow: one in flight, four queued, sixth dropped
        for (int i = 0; i < 6; i++) bus_write(TXD, $urandom);
        bus_idle();
        read_check("ovf_full", CON, 32'h2C);
        bus_write(CON, 32'h20);
        bus_idle();
        read_check("ovf_w1c", CON, 32'h0C);
        wait_until(tx_free);
        read_check("ovf_drained", CON, 32'h12);
        bus_write(CON, 32'h2);
        bus_idle();

        // Reset in the middle of a frame
        bus_write(TXD, $urandom);
        bus_write(TXD, $urandom);
        bus_idle();
        wait_until(starts_q[starts_q.size() - 2] + 34);
        reset = 1'b1;
        epoch++;
        exp_q.delete();
        starts_q.delete();
        tx_free = 0;
        ovf_m = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("midframe_reset_tx", {31'd0, UART_TX}, 32'd1);
        check("midframe_reset_irq", {31'd0, IRQ}, 32'd0);
        read_check("midframe_reset_con", CON, 32'h10);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (UART_TX !== 1'b1) bad++;
        end
        check("idle_after_reset", 32'(bad), 32'd0);
        read_check("con_after_reset_idle", CON, 32'h10);

        // Unmapped address
        read_check("unmapped_read", UNM, 32'h0);
        bus_write(UNM, 32'hFF);
        bus_idle();
        read_check("unmapped_con", CON, 32'h10);
        read_check("unmapped_txd", TXD, 32'h0);
        Addr = CON;
        MemRead = 1'b0;
        #1;
        check("no_read_strobe", ReadData, 32'h0);
        repeat (120) @(negedge clk);
        check("unmapped_no_frame", {31'd0, UART_TX}, 32'd1);

        // Randomized bursts with gaps
        bus_write(CON, 32'h1);
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            bus_write(TXD, {24'd0, b});
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 150)) : 0;
            if (gap > 0) begin
                bus_idle();
                repeat (gap - 1) @(negedge clk);
            end
        end
        bus_idle();
        wait_until(tx_free + 2);
        read_check("random_final_con", CON, 32'h13 | {26'd0, ovf_m, 5'd0});
        check("random_final_irq", {31'd0, IRQ}, 32'd1);
        repeat (5) @(negedge clk);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter peripheral that answers the CPU's MEM-stage peripheral bus (read/write strobe, 32-bit address, 32-bit write data). Software writes bytes to a data register, and they queue in a small FIFO. The bytes are then serialised as 8N1 frames on `UART_TX`. A maskable "queue drained" interrupt is raised on the CPU's `IRQ` line. The block is the bus responder for the pipeline's load/store path; the pipeline is the initiator.

## Interface
- `CLK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 9600, line rate; `DIVISOR = CLK_FREQ/BAUD` (integer, truncated), cycles per bit, must be ≥ 2.
- `FIFO_DEPTH`, 4, TX FIFO entries (power of two).
- `BASE_ADDR`, 32'h4000_0018, address of TXD; CON is at `BASE_ADDR+4`.
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `MemRead` in 1: read strobe.
- `MemWrite` in 1: write strobe, sampled on the `clk` rising edge.
- `Addr` in 32: byte address; only exact matches to TXD/CON select the block.
- `WriteData` in 32: write data.
- `ReadData` out 32: combinational read data; 0 when not selected or `MemRead`=0.
- `IRQ` out 1: registered interrupt, `CON.ie & CON.done`.
- `UART_TX` out 1: serial line, registered, idle high.

## Operation
- TXD (`BASE_ADDR`):
  - A write pushes `WriteData[7:0]` into the FIFO.
  - A read returns `{24'b0, last byte written}`.
- CON (`BASE_ADDR+4`):
  - bit0 `ie`: RW.
  - bit1 `done`: sticky, write-1-clears.
  - bit2 `busy`: RO, FSM not IDLE.
  - bit3 `full`: RO.
  - bit4 `empty`: RO.
  - bit5 `ovf`: sticky, write-1-clears.
  - Other bits read 0 and ignore writes.
- Writes to any other address: ignored. Reads of any other address: `ReadData`=0.
- FIFO full is evaluated before the edge. A TXD write while full is dropped and sets `ovf`, even if a pop occurs on the same edge.
- FSM states IDLE, START, DATA, STOP; a baud counter runs 0..DIVISOR-1 and a bit index runs 0..7.
  - IDLE: if the FIFO is non-empty, pop into the shift register, `UART_TX`<=0, counter<=0, go to START.
  - START: after DIVISOR cycles, drive bit0, go to DATA.
  - DATA: shift LSB-first, each bit held DIVISOR cycles. After bit7, drive 1 and go to STOP.
  - STOP: after DIVISOR cycles:
    - FIFO non-empty: pop and go directly to START with `UART_TX`<=0 (no idle gap).
    - FIFO empty: go to IDLE and set `done`.
- `done` set and a W1C clear on the same edge: set wins. Same rule for `ovf`.
- A byte queued while a frame is in flight never disturbs that frame.

## Timing
- Reset values:
  - `UART_TX`=1, `IRQ`=0.
  - FIFO empty; CON = 0x10 (`empty`=1, all others 0).
  - Last-TXD byte = 0; FSM in IDLE.
- Reset mid-frame aborts the frame: `UART_TX` is 1 on the cycle after the reset edge, and the FIFO contents are discarded.
- Start latency: a write at edge E0 into an idle, empty block drives `UART_TX` low after edge E1.
- Frame length: exactly `10*DIVISOR` cycles. Back-to-back frames are contiguous.
- `busy` is asserted from E1 until the edge that enters IDLE.
- `done` and `IRQ` rise on that same edge, or on the next edge for `IRQ` (`IRQ` is registered from the CON state; one-cycle lag).
- Status bits visible on `ReadData` reflect register state before the current edge.

## Structure
- Package `uart_pkg`:
  - TXD/CON offsets.
  - CON bit indices.
  - FSM state enum {IDLE, START, DATA, STOP}.
  - Baud-counter width function `$clog2(DIVISOR)`.
- Sub-module `uart_tx_fifo`: synchronous FIFO with wrapping pointers plus an extra occupancy bit. Ports: push, pop, din, dout, full, empty. Pop when empty is ignored.
- Top level holds: address decode, CON register, FSM, shift register, baud counter.

## Test plan
All cases use CLK_FREQ=1000, BAUD=100, so DIVISOR=10.
- Reset, then idle 50 cycles → `UART_TX`=1, `IRQ`=0, read CON = 0x10.
- Write CON=0x1, then TXD=0xA5 → `UART_TX` low 10 cycles starting E1; bits 1,0,1,0,0,1,0,1 at 10 cycles each; stop high; `done`=1 at cycle 101; `IRQ`=1 one cycle later. Write CON=0x3 → `IRQ`=0.
- Write 0x11, 0x22, 0x33 on consecutive cycles → three contiguous 100-cycle frames with no idle gap; `done` sets only after the third stop bit.
- Fill the FIFO (5 writes while the first frame is in flight: 1 in flight + 4 queued), then a 6th write → 6th byte never appears on the line; `ovf`=1; W1C of bit5 clears it.
- Assert `reset` at cycle 35 of a frame → `UART_TX`=1 next cycle, CON=0x10, no further frames.
- Read unmapped `BASE_ADDR+8` and write it with 0xFF → `ReadData`=0; CON and FIFO unchanged.
